// File: rtl/wb_arbiter.sv
// wb_arbiter: per-unit result FIFOs with round-robin serialisation onto the single ROB writeback port.
package wb_arbiter_pkg;
   typedef logic [3:0] ExpCode_t;
endpackage

module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DATA      = 32,
   parameter int ROB_DEPTH = 16,
   parameter int UNITS     = 4,
   parameter int BUF_DEPTH = 2,
   parameter int ROB       = $clog2(ROB_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_,
   input  logic                  flush_,
   input  logic [UNITS-1:0]      ex_e_,
   input  logic [UNITS*ROB-1:0]  ex_rob_id,
   input  logic [UNITS*DATA-1:0] ex_data,
   input  logic [UNITS-1:0]      ex_exp_,
   input  ExpCode_t [UNITS-1:0]  ex_exp_code,
   input  logic [UNITS-1:0]      ex_pred_miss_,
   input  logic [UNITS-1:0]      ex_jump_miss_,
   output logic [UNITS-1:0]      ex_busy,
   output logic                  wb_e_,
   output logic [ROB-1:0]        wb_rob_id,
   output logic [DATA-1:0]       wb_data,
   output logic                  wb_exp_,
   output ExpCode_t              wb_exp_code,
   output logic                  wb_pred_miss_,
   output logic                  wb_jump_miss_
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int UW = $clog2(UNITS);

   typedef struct packed {
      logic [ROB-1:0]  rob_id;
      logic [DATA-1:0] data;
      logic            exp_;
      ExpCode_t        exp_code;
      logic            pred_miss_;
      logic            jump_miss_;
   } ent_t;

   localparam ent_t WB_RST = '{rob_id: '0, data: '0, exp_: 1'b1, exp_code: '0,
                               pred_miss_: 1'b1, jump_miss_: 1'b1};

   ent_t          mem_q [UNITS][BUF_DEPTH];
   ent_t          mem_d [UNITS][BUF_DEPTH];
   ent_t          in_ent [UNITS];
   logic [CW-1:0] cnt_q [UNITS];
   logic [CW-1:0] cnt_d [UNITS];
   logic [PW-1:0] wp_q [UNITS];
   logic [PW-1:0] wp_d [UNITS];
   logic [PW-1:0] rp_q [UNITS];
   logic [PW-1:0] rp_d [UNITS];
   logic [UW-1:0] last_q, last_d, gnt;
   logic          gnt_v;
   logic [UNITS-1:0] push, pop;
   ent_t          wb_q, wb_d;
   logic          wb_e_q, wb_e_d;

   for (genvar g = 0; g < UNITS; g++) begin : g_unit
      assign in_ent[g] = '{rob_id: ex_rob_id[g*ROB +: ROB], data: ex_data[g*DATA +: DATA],
                           exp_: ex_exp_[g], exp_code: ex_exp_code[g],
                           pred_miss_: ex_pred_miss_[g], jump_miss_: ex_jump_miss_[g]};
      assign ex_busy[g] = cnt_q[g] == CW'(BUF_DEPTH);
      // A full FIFO drops its input even when it is being popped this cycle.
      assign push[g] = flush_ && !ex_e_[g] && !ex_busy[g];
      assign pop[g]  = flush_ && gnt_v && gnt == UW'(g);
   end

   always_comb begin
      gnt_v = 1'b0;
      gnt   = last_q;
      for (int k = 1; k <= UNITS; k++) begin
         if (!gnt_v && cnt_q[(int'(last_q) + k) % UNITS] != '0) begin
            gnt_v = 1'b1;
            gnt   = UW'((int'(last_q) + k) % UNITS);
         end
      end
   end

   always_comb begin
      mem_d  = mem_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      last_d = last_q;
      wb_d   = wb_q;
      wb_e_d = 1'b1;
      for (int i = 0; i < UNITS; i++) begin
         if (push[i]) begin
            mem_d[i][wp_q[i]] = in_ent[i];
            wp_d[i] = wp_q[i] + 1'b1;
         end
         if (pop[i]) rp_d[i] = rp_q[i] + 1'b1;
         cnt_d[i] = flush_ ? cnt_q[i] + CW'(push[i]) - CW'(pop[i]) : '0;
         if (!flush_) begin
            wp_d[i] = '0;
            rp_d[i] = '0;
         end
      end
      if (flush_ && gnt_v) begin
         wb_d   = mem_q[gnt][rp_q[gnt]];
         wb_e_d = 1'b0;
         last_d = gnt;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < UNITS; i++) begin
            cnt_q[i] <= '0;
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
         end
         last_q <= UW'(UNITS - 1);
         wb_q   <= WB_RST;
         wb_e_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         last_q <= last_d;
         wb_q   <= wb_d;
         wb_e_q <= wb_e_d;
      end
   end

   // Storage needs no reset: an entry is only read after being written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign wb_e_         = wb_e_q;
   assign wb_rob_id     = wb_q.rob_id;
   assign wb_data       = wb_q.data;
   assign wb_exp_       = wb_q.exp_;
   assign wb_exp_code   = wb_q.exp_code;
   assign wb_pred_miss_ = wb_q.pred_miss_;
   assign wb_jump_miss_ = wb_q.jump_miss_;
endmodule
